// File: rtl/pll_drp_resp_pkg.sv
// Shared definitions for the PLL DRP responder: FSM encoding, default port
// widths (also used by the DRP initiator) and a small latency helper.
package pll_drp_resp_pkg;

    // Default DRP address and data widths shared with the initiator side.
    localparam int DRP_AW = 5;
    localparam int DRP_DW = 16;

    // Width of the DEN-to-DRDY latency counter; latencies 1..15 are supported.
    localparam int LAT_W = 4;

    // Access FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } drp_state_e;

    // Value loaded into the latency counter when DEN is accepted. WAIT ends on
    // the cycle the counter is already zero, so the load is LAT-1.
    function automatic logic [LAT_W-1:0] lat_load(input int lat);
        return LAT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/drp_lock_model.sv
// PLL lock model: LOCKED rises LOCK_CYC cycles after RST_PLL is released and
// drops on the first edge that sees RST_PLL high again.
module drp_lock_model #(
    parameter int CBW      = 8,
    parameter int LOCK_CYC = 64
) (
    input  logic CLK,
    input  logic RSTX,
    input  logic RST_PLL,
    output logic LOCKED
);

    localparam logic [CBW-1:0] LAST_CNT = CBW'(LOCK_CYC - 1);

    logic [CBW-1:0] cnt_reg;
    logic           locked_reg;

    // Count cycles out of PLL reset; the counter freezes once lock is reached
    // and restarts from zero whenever RST_PLL is seen high.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            cnt_reg    <= '0;
            locked_reg <= 1'b0;
        end else if (RST_PLL) begin
            cnt_reg    <= '0;
            locked_reg <= 1'b0;
        end else if (!locked_reg) begin
            if (cnt_reg == LAST_CNT) begin
                locked_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign LOCKED = locked_reg;

endmodule

// File: rtl/pll_drp_resp.sv
// DRP responder standing in for a PLL primitive: a register file behind a
// fixed-latency DEN/DRDY handshake, plus the RST_PLL/LOCKED lock model.
module pll_drp_resp
    import pll_drp_resp_pkg::*;
#(
    parameter int AW       = DRP_AW,
    parameter int DW       = DRP_DW,
    parameter int LAT      = 4,
    parameter int LOCK_CYC = 64,
    parameter int CBW      = 8
) (
    input  logic          CLK,
    input  logic          RSTX,
    input  logic          DEN,
    input  logic          DWE,
    input  logic [AW-1:0] DADDR,
    input  logic [DW-1:0] DI,
    output logic [DW-1:0] DO,
    output logic          DRDY,
    input  logic          RST_PLL,
    output logic          LOCKED,
    output logic          ERR_BUSY,
    output logic          ERR_NRST
);

    localparam int               DEPTH    = 1 << AW;
    localparam logic [LAT_W-1:0] LAT_INIT = lat_load(LAT);

    drp_state_e       state_reg;
    logic [LAT_W-1:0] lat_cnt_reg;
    logic             we_reg;
    logic [AW-1:0]    addr_reg;
    logic [DW-1:0]    data_reg;
    logic [DW-1:0]    do_reg;
    logic             drdy_reg;
    logic             err_busy_reg;
    logic             err_nrst_reg;

    logic [DW-1:0]    regs [DEPTH];
    logic             resp_now;
    logic [DEPTH-1:0] wr_hit;

    // The access completes on the edge that leaves WAIT with the counter at zero.
    assign resp_now = (state_reg == ST_WAIT) && (lat_cnt_reg == '0);

    // Register file: each entry is written on the completing edge of a write
    // to its address; RSTX wipes the contents.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_regs
            assign wr_hit[gi] = resp_now && we_reg && (addr_reg == AW'(gi));

            // One DRP register with asynchronous clear.
            always_ff @(posedge CLK or negedge RSTX) begin
                if (!RSTX) begin
                    regs[gi] <= '0;
                end else if (wr_hit[gi]) begin
                    regs[gi] <= data_reg;
                end
            end
        end
    endgenerate

    // Access FSM: latch the request in IDLE, count down in WAIT, then drive a
    // single-cycle DRDY with registered DO; DEN outside IDLE is dropped and flagged.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_reg    <= ST_IDLE;
            lat_cnt_reg  <= '0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            do_reg       <= '0;
            drdy_reg     <= 1'b0;
            err_busy_reg <= 1'b0;
            err_nrst_reg <= 1'b0;
        end else begin
            drdy_reg     <= 1'b0;
            do_reg       <= '0;
            err_busy_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (DEN) begin
                        we_reg      <= DWE;
                        addr_reg    <= DADDR;
                        data_reg    <= DI;
                        lat_cnt_reg <= LAT_INIT;
                        state_reg   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    err_busy_reg <= DEN;
                    if (lat_cnt_reg == '0) begin
                        state_reg <= ST_RESP;
                        drdy_reg  <= 1'b1;
                        // Writes return zero; reads return the stored word.
                        do_reg    <= we_reg ? '0 : regs[addr_reg];
                        if (we_reg && !RST_PLL) begin
                            err_nrst_reg <= 1'b1;
                        end
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    err_busy_reg <= DEN;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign DO       = do_reg;
    assign DRDY     = drdy_reg;
    assign ERR_BUSY = err_busy_reg;
    assign ERR_NRST = err_nrst_reg;

    drp_lock_model #(
        .CBW      (CBW),
        .LOCK_CYC (LOCK_CYC)
    ) u_lock (
        .CLK     (CLK),
        .RSTX    (RSTX),
        .RST_PLL (RST_PLL),
        .LOCKED  (LOCKED)
    );

endmodule

// File: tb/tb_pll_drp_resp.sv
// Self-checking bench for pll_drp_resp: directed scenarios plus randomized
// accesses, compared against a transaction-level memory / lock-time model.
module tb_pll_drp_resp;

    localparam int AW       = 5;
    localparam int DW       = 16;
    localparam int LAT      = 4;
    localparam int LOCK_CYC = 64;
    localparam int CBW      = 8;
    localparam int DEPTH    = 1 << AW;

    logic          CLK = 1'b0;
    logic          RSTX = 1'b0;
    logic          DEN = 1'b0;
    logic          DWE = 1'b0;
    logic [AW-1:0] DADDR = '0;
    logic [DW-1:0] DI = '0;
    logic [DW-1:0] DO;
    logic          DRDY;
    logic          RST_PLL = 1'b1;
    logic          LOCKED;
    logic          ERR_BUSY;
    logic          ERR_NRST;

    int tests = 0;
    int fails = 0;

    // Reference state: register contents, sticky no-reset-write flag, and the
    // number of cycles the PLL has been out of reset (saturating at LOCK_CYC).
    logic [DW-1:0] mem_model [DEPTH];
    bit            nrst_model;
    int            since;

    always #5 CLK = ~CLK;

    pll_drp_resp #(
        .AW       (AW),
        .DW       (DW),
        .LAT      (LAT),
        .LOCK_CYC (LOCK_CYC),
        .CBW      (CBW)
    ) dut (
        .CLK      (CLK),
        .RSTX     (RSTX),
        .DEN      (DEN),
        .DWE      (DWE),
        .DADDR    (DADDR),
        .DI       (DI),
        .DO       (DO),
        .DRDY     (DRDY),
        .RST_PLL  (RST_PLL),
        .LOCKED   (LOCKED),
        .ERR_BUSY (ERR_BUSY),
        .ERR_NRST (ERR_NRST)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; update the lock model from the values seen at the edge
    // and check LOCKED shortly after it.
    task automatic tick();
        logic rp;
        rp = RST_PLL;
        @(posedge CLK);
        if (!RSTX || rp) since = 0;
        else if (since < LOCK_CYC) since++;
        #1;
        chk("locked", {31'b0, LOCKED}, {31'b0, since >= LOCK_CYC});
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
        nrst_model = 1'b0;
    endtask

    // One DRP access. busy_at = k (1..LAT+1) fires a stray DEN just before the
    // k-th edge after the accepted one; 0 means no stray DEN.
    task automatic do_access(input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int busy_at);
        logic [DW-1:0] exp_do;
        DEN = 1'b1; DWE = we; DADDR = a; DI = d;
        tick();
        DEN = 1'b0; DWE = 1'b0;
        chk("drdy_accept", {31'b0, DRDY}, 32'd0);
        chk("busy_accept", {31'b0, ERR_BUSY}, 32'd0);
        for (int k = 1; k <= LAT + 1; k++) begin
            if (busy_at == k) begin
                DEN = 1'b1; DWE = 1'($urandom); DADDR = AW'($urandom); DI = DW'($urandom);
            end
            tick();
            DEN = 1'b0; DWE = 1'b0;
            chk("err_busy", {31'b0, ERR_BUSY}, {31'b0, busy_at == k});
            if (k == LAT) begin
                exp_do = we ? '0 : mem_model[a];
                chk("drdy_resp", {31'b0, DRDY}, 32'd1);
                chk(we ? "do_write" : "do_read", {16'b0, DO}, {16'b0, exp_do});
                if (we) begin
                    mem_model[a] = d;
                    if (!RST_PLL) nrst_model = 1'b1;
                end
            end else begin
                chk("drdy_idle", {31'b0, DRDY}, 32'd0);
                chk("do_idle", {16'b0, DO}, 32'd0);
            end
        end
        chk("err_nrst", {31'b0, ERR_NRST}, {31'b0, nrst_model});
        $display("[TB] access we=%0d addr=%0d data=%h busy_at=%0d", we, a, d, busy_at);
    endtask

    initial begin
        clear_model();
        since = 0;

        // 1: reset values, then a read of an untouched register.
        repeat (3) tick();
        chk("rst_do", {16'b0, DO}, 32'd0);
        chk("rst_drdy", {31'b0, DRDY}, 32'd0);
        chk("rst_busy", {31'b0, ERR_BUSY}, 32'd0);
        chk("rst_nrst", {31'b0, ERR_NRST}, 32'd0);
        RSTX = 1'b1;
        tick();
        chk("post_rst_drdy", {31'b0, DRDY}, 32'd0);
        chk("post_rst_do", {16'b0, DO}, 32'd0);
        do_access(1'b0, 5'd5, '0, 0);

        // 2: write then read back.
        do_access(1'b1, 5'd3, 16'hA5C3, 0);
        do_access(1'b0, 5'd3, '0, 0);

        // 3: stray DEN during WAIT and during the DRDY cycle.
        do_access(1'b1, 5'd3, 16'h1234, 2);
        do_access(1'b0, 5'd3, '0, LAT + 1);
        do_access(1'b0, 5'd3, '0, 1);

        // Randomized accesses with random gaps and stray strobes.
        repeat (40) begin
            do_access(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                      int'($urandom_range(0, LAT + 1)));
            repeat ($urandom_range(0, 2)) tick();
        end
        for (int i = 0; i < DEPTH; i += 7) do_access(1'b0, AW'(i), '0, 0);

        // 4: lock timing, aborted count, and drop on re-assert.
        RST_PLL = 1'b1;
        repeat (10) tick();
        RST_PLL = 1'b0;
        repeat (30) tick();
        RST_PLL = 1'b1;
        tick();
        RST_PLL = 1'b0;
        repeat (LOCK_CYC - 1) tick();
        chk("lock_early", {31'b0, LOCKED}, 32'd0);
        tick();
        chk("lock_exact", {31'b0, LOCKED}, 32'd1);
        $display("[TB] lock after %0d cycles", LOCK_CYC);
        RST_PLL = 1'b1;
        tick();
        chk("lock_drop", {31'b0, LOCKED}, 32'd0);
        repeat (6) begin
            RST_PLL = 1'b1;
            repeat ($urandom_range(1, 5)) tick();
            RST_PLL = 1'b0;
            repeat ($urandom_range(1, 100)) tick();
            $display("[TB] lock segment locked=%0d since=%0d", LOCKED, since);
        end

        // 5: write with RST_PLL low sets the sticky flag; the write still lands.
        RST_PLL = 1'b0;
        do_access(1'b1, 5'd9, 16'hBEEF, 0);
        chk("nrst_set", {31'b0, ERR_NRST}, 32'd1);
        repeat (5) tick();
        do_access(1'b0, 5'd9, '0, 0);
        chk("nrst_held", {31'b0, ERR_NRST}, 32'd1);

        // 6: RSTX pulse while a write is in WAIT.
        DEN = 1'b1; DWE = 1'b1; DADDR = 5'd7; DI = 16'h7777;
        tick();
        DEN = 1'b0; DWE = 1'b0;
        tick();
        RSTX = 1'b0;
        #1;
        chk("rstx_drdy", {31'b0, DRDY}, 32'd0);
        chk("rstx_nrst", {31'b0, ERR_NRST}, 32'd0);
        tick();
        RSTX = 1'b1;
        clear_model();
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            chk("lost_drdy", {31'b0, DRDY}, 32'd0);
        end
        $display("[TB] rstx pulse during WAIT");
        do_access(1'b0, 5'd7, '0, 0);
        do_access(1'b0, 5'd9, '0, 0);
        do_access(1'b0, 5'd3, '0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
